// File: rtl/ice51_boot_ctrl_if.sv
// Boot controller bus bundle: UART rx byte in, code-memory port out, core reset and serial forward.
// slave = boot controller side, master = surrounding system side.
interface ice51_boot_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              i_rx_valid;
  logic [7:0]        i_rx_data;
  logic [ADDR_W-1:0] i_core_addr;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        o_mem_wdata;
  logic              o_core_nrst;
  logic              o_core_rx_valid;
  logic [7:0]        o_core_rx_data;
  logic              o_loading;

  modport slave (
    input  i_rx_valid, i_rx_data, i_core_addr,
    output o_mem_we, o_mem_addr, o_mem_wdata, o_core_nrst,
           o_core_rx_valid, o_core_rx_data, o_loading
  );

  modport master (
    output i_rx_valid, i_rx_data, i_core_addr,
    input  o_mem_we, o_mem_addr, o_mem_wdata, o_core_nrst,
           o_core_rx_valid, o_core_rx_data, o_loading
  );
endinterface

// File: rtl/ice51_boot_ctrl.sv
// Boot sequencer: streams UART bytes into code memory, releases the core, then forwards UART bytes to it.
// Latency: 1 cycle for writes and forwards; no backpressure, every rx strobe is consumed or dropped.
module ice51_boot_ctrl #(
  parameter int MEM_SIZE       = 1024,
  parameter int ADDR_W         = 10,
  parameter bit PRELOAD        = 1'b0,
  parameter int RELEASE_CYCLES = 16
) (
  input logic              i_clk,
  input logic              i_nrst,
  ice51_boot_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_SIZE - 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(RELEASE_CYCLES);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam state_t RST_STATE = PRELOAD ? ST_RELEASE : ST_LOAD;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              nrst_q, nrst_d;
  logic              rxv_q, rxv_d;
  logic [7:0]        rxd_q, rxd_d;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= RST_STATE;
      ptr_q   <= '0;
      cnt_q   <= CNT_INIT;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      nrst_q  <= 1'b0;
      rxv_q   <= 1'b0;
      rxd_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      nrst_q  <= nrst_d;
      rxv_q   <= rxv_d;
      rxd_q   <= rxd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    nrst_d  = nrst_q;
    rxv_d   = 1'b0;
    rxd_d   = rxd_q;

    unique case (state_q)
      ST_LOAD: begin
        if (bus.i_rx_valid) begin
          we_d    = 1'b1;
          waddr_d = ptr_q;
          wdata_d = bus.i_rx_data;
          // Pointer parks on the last address instead of wrapping.
          if (ptr_q == LAST_PTR) begin
            state_d = ST_RELEASE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        // The settle count starts only after the final write has left the port.
        if (!we_q) begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_RUN;
            nrst_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_RUN: begin
        rxv_d = bus.i_rx_valid;
        if (bus.i_rx_valid) begin
          rxd_d = bus.i_rx_data;
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  assign bus.o_mem_we        = we_q;
  assign bus.o_mem_wdata     = wdata_q;
  assign bus.o_mem_addr      = we_q ? waddr_q
                             : ((state_q == ST_LOAD) ? ptr_q : bus.i_core_addr);
  assign bus.o_core_nrst     = nrst_q;
  assign bus.o_core_rx_valid = rxv_q;
  assign bus.o_core_rx_data  = rxd_q;
  assign bus.o_loading       = (state_q == ST_LOAD);

endmodule

// File: tb/tb_ice51_boot_ctrl.sv
// Bench for ice51_boot_ctrl: a loading instance (MEM_SIZE=4) and a PRELOAD instance checked against a queue model.
module tb_ice51_boot_ctrl;
  localparam int MS = 4;
  localparam int AW = 10;
  localparam int RC = 6;

  logic clk = 1'b0;
  logic nrst_a = 1'b0;
  logic nrst_b = 1'b0;
  always #5 clk = ~clk;

  ice51_boot_ctrl_if #(.ADDR_W(AW)) ba ();
  ice51_boot_ctrl_if #(.ADDR_W(AW)) bb ();

  ice51_boot_ctrl #(.MEM_SIZE(MS), .ADDR_W(AW), .PRELOAD(1'b0), .RELEASE_CYCLES(RC)) dut_a (
    .i_clk(clk), .i_nrst(nrst_a), .bus(ba.slave));
  ice51_boot_ctrl #(.MEM_SIZE(MS), .ADDR_W(AW), .PRELOAD(1'b1), .RELEASE_CYCLES(RC)) dut_b (
    .i_clk(clk), .i_nrst(nrst_b), .bus(bb.slave));

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [AW-1:0] wa_addr[$];
  logic [7:0]    wa_data[$];
  int            wa_cyc[$];
  logic [7:0]    fa[$];
  int            wb_n = 0;
  int            fb_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed write / forward streams, sampled mid-cycle.
  always @(negedge clk) begin
    if (ba.o_mem_we === 1'b1) begin
      wa_addr.push_back(ba.o_mem_addr);
      wa_data.push_back(ba.o_mem_wdata);
      wa_cyc.push_back(cyc);
    end
    if (ba.o_core_rx_valid === 1'b1) fa.push_back(ba.o_core_rx_data);
    if (bb.o_mem_we === 1'b1) wb_n++;
    if (bb.o_core_rx_valid === 1'b1) fb_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    ba.i_rx_valid = 1'b1;
    ba.i_rx_data  = d;
    @(negedge clk);
    ba.i_rx_valid = 1'b0;
  endtask

  task automatic clear_a();
    wa_addr.delete();
    wa_data.delete();
    wa_cyc.delete();
    fa.delete();
  endtask

  task automatic reset_a();
    @(negedge clk);
    nrst_a = 1'b0;
    repeat (2) @(negedge clk);
    clear_a();
    nrst_a = 1'b1;
    @(negedge clk);
  endtask

  task automatic cycles_to_nrst_a(output int n);
    n = 0;
    while (ba.o_core_nrst !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    logic [7:0]    exp2[4];
    logic [7:0]    exp_d[$];
    logic [7:0]    exp_f[$];
    logic [7:0]    d;
    logic [AW-1:0] ca;
    int            n;
    bit            v;

    exp2 = '{8'h02, 8'h00, 8'h03, 8'h80};
    ba.i_rx_valid = 1'b0; ba.i_rx_data = '0; ba.i_core_addr = '0;
    bb.i_rx_valid = 1'b0; bb.i_rx_data = '0; bb.i_core_addr = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst core_nrst", ba.o_core_nrst, 0);
    chk("rst mem_we", ba.o_mem_we, 0);
    chk("rst loading", ba.o_loading, 1);
    chk("rst rx_valid", ba.o_core_rx_valid, 0);
    chk("rst wdata", ba.o_mem_wdata, 0);
    chk("rst rx_data", ba.o_core_rx_data, 0);
    chk("rst mem_addr", ba.o_mem_addr, 0);

    // Directed load with random gaps
    nrst_a = 1'b1;
    ba.i_core_addr = 10'h155;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_a(exp2[i]);
      chk("load core_nrst low", ba.o_core_nrst, 0);
    end
    chk("load last addr", ba.o_mem_addr, 3);
    chk("load ends", ba.o_loading, 0);
    cycles_to_nrst_a(n);
    chk("write to release cycles", n, RC + 1);
    chk("run mem_addr mux", ba.o_mem_addr, 10'h155);
    @(negedge clk);
    chk("load write count", wa_addr.size(), 4);
    for (int i = 0; i < 4 && i < wa_addr.size(); i++) begin
      chk("load addr", wa_addr[i], i);
      chk("load data", wa_data[i], exp2[i]);
    end

    // Back-to-back random bytes
    reset_a();
    exp_d.delete();
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      exp_d.push_back(d);
      ba.i_rx_valid = 1'b1;
      ba.i_rx_data  = d;
      @(negedge clk);
    end
    ba.i_rx_valid = 1'b0;
    @(negedge clk);
    chk("b2b write count", wa_addr.size(), 4);
    for (int i = 0; i < 4 && i < wa_addr.size(); i++) begin
      chk("b2b addr", wa_addr[i], i);
      chk("b2b data", wa_data[i], exp_d[i]);
      chk("b2b consecutive", wa_cyc[i] - wa_cyc[0], i);
    end
    cycles_to_nrst_a(n);
    chk("b2b released", ba.o_core_nrst, 1);
    @(negedge clk);

    // Run mode forwarding
    clear_a();
    ba.i_core_addr = 10'h1F3;
    #1;
    chk("run addr 1F3", ba.o_mem_addr, 10'h1F3);
    chk("run we low", ba.o_mem_we, 0);
    @(negedge clk);
    send_a(8'h5A);
    chk("fwd valid", ba.o_core_rx_valid, 1);
    chk("fwd data", ba.o_core_rx_data, 8'h5A);
    @(negedge clk);
    chk("fwd valid drop", ba.o_core_rx_valid, 0);
    chk("fwd data hold", ba.o_core_rx_data, 8'h5A);
    fa.delete();
    exp_f.delete();
    for (int i = 0; i < 30; i++) begin
      v  = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      ca = AW'($urandom);
      ba.i_rx_valid  = v;
      ba.i_rx_data   = d;
      ba.i_core_addr = ca;
      if (v) exp_f.push_back(d);
      #1;
      chk("run addr track", ba.o_mem_addr, ca);
      @(negedge clk);
    end
    ba.i_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("fwd count", fa.size(), exp_f.size());
    for (int i = 0; i < exp_f.size() && i < fa.size(); i++)
      chk("fwd stream", fa[i], exp_f[i]);
    chk("run no writes", wa_addr.size(), 0);
    chk("run stays released", ba.o_core_nrst, 1);

    // Reset in the middle of a load
    reset_a();
    send_a(8'($urandom));
    send_a(8'($urandom));
    #2;
    nrst_a = 1'b0;
    #1;
    chk("midrst core_nrst", ba.o_core_nrst, 0);
    chk("midrst we", ba.o_mem_we, 0);
    chk("midrst loading", ba.o_loading, 1);
    @(negedge clk);
    clear_a();
    nrst_a = 1'b1;
    @(negedge clk);
    send_a(8'hAA);
    @(negedge clk);
    chk("midrst write count", wa_addr.size(), 1);
    if (wa_addr.size() > 0) begin
      chk("midrst addr", wa_addr[0], 0);
      chk("midrst data", wa_data[0], 8'hAA);
    end
    chk("midrst core_nrst low", ba.o_core_nrst, 0);

    // PRELOAD instance
    chk("pre rst loading", bb.o_loading, 0);
    chk("pre rst core_nrst", bb.o_core_nrst, 0);
    @(negedge clk);
    nrst_b = 1'b1;
    n = 0;
    while (bb.o_core_nrst !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      bb.i_rx_valid = (n == 1);
      bb.i_rx_data  = 8'hC3;
    end
    bb.i_rx_valid = 1'b0;
    chk("pre release cycles", n, RC);
    repeat (2) @(negedge clk);
    chk("pre no writes", wb_n, 0);
    chk("pre release drop", fb_n, 0);
    bb.i_rx_valid = 1'b1;
    bb.i_rx_data  = 8'h3C;
    @(negedge clk);
    bb.i_rx_valid = 1'b0;
    chk("pre run fwd data", bb.o_core_rx_data, 8'h3C);
    @(negedge clk);
    chk("pre run fwd count", fb_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
